// File: rtl/traffic_rr.sv
// traffic_rr: N-way demand-driven round-robin traffic-light controller.
// Serves one approach at a time with all-red clearance between grants,
// holds green while nobody else waits, and offers night flashing amber.
module traffic_rr #(
  parameter int NUM_DIR = 4,
  parameter int T_CLEAR = 3,
  parameter int T_RA    = 2,
  parameter int T_GREEN = 20,
  parameter int T_AMBER = 4,
  parameter int T_FLASH = 8,
  localparam int DIRW   = $clog2(NUM_DIR)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_DIR-1:0]   demand,
  input  logic                 night_mode,
  output logic [4*NUM_DIR-1:0] lamp,
  output logic [DIRW-1:0]      active_dir,
  output logic [2:0]           state_o
);

  localparam logic [2:0] S_ALL_RED   = 3'd0;
  localparam logic [2:0] S_RED_AMBER = 3'd1;
  localparam logic [2:0] S_GREEN     = 3'd2;
  localparam logic [2:0] S_AMBER     = 3'd3;
  localparam logic [2:0] S_FLASH     = 3'd4;

  localparam logic [3:0] L_GREEN = 4'b1000;
  localparam logic [3:0] L_RA    = 4'b0100;
  localparam logic [3:0] L_RED   = 4'b0010;
  localparam logic [3:0] L_AMBER = 4'b0001;
  localparam logic [3:0] L_DARK  = 4'b0000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Timer holds values up to T_x-1 for the longest timed state.
  localparam int T_MAX = max2(max2(max2(T_CLEAR, T_RA), max2(T_GREEN, T_AMBER)), T_FLASH);
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  // Approach index a+k, wrapped modulo NUM_DIR.
  function automatic logic [DIRW-1:0] wrap_add(input logic [DIRW-1:0] a, input int k);
    int s;
    s = (int'(a) + k) % NUM_DIR;
    return DIRW'(s);
  endfunction

  logic [2:0]           state, state_n;
  logic [TW-1:0]        timer, timer_n;
  logic [DIRW-1:0]      dir_n, next_dir;
  logic [NUM_DIR-1:0]   pending, pending_n, dir_oh, mask, clr;
  logic                 flash_ph, flash_n, ra_done, expired;
  logic [4*NUM_DIR-1:0] lamp_n;

  assign expired = (timer == '0);
  assign state_o = state;
  assign dir_oh  = NUM_DIR'(1) << active_dir;

  // Round-robin pick: closest pending approach after active_dir, itself last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    next_dir = active_dir;
    // Walk from farthest to nearest so the nearest pending approach wins.
    for (int i = NUM_DIR; i >= 1; i--) begin
      if (pending[wrap_add(active_dir, i)]) next_dir = wrap_add(active_dir, i);
    end
  end

  // Phase sequencing and timer reload on state entry.
  always_comb begin
    state_n = state;
    timer_n = expired ? '0 : timer - TW'(1);
    dir_n   = active_dir;
    flash_n = flash_ph;
    ra_done = 1'b0;
    case (state)
      S_ALL_RED: begin
        if (expired) begin
          if (night_mode) begin
            state_n = S_FLASH;
            timer_n = TW'(T_FLASH - 1);
            flash_n = 1'b0;
          end else if (|pending) begin
            state_n = S_RED_AMBER;
            timer_n = TW'(T_RA - 1);
            dir_n   = next_dir;
          end
        end
      end
      S_RED_AMBER: begin
        if (expired) begin
          state_n = S_GREEN;
          timer_n = TW'(T_GREEN - 1);
          ra_done = 1'b1;
        end
      end
      S_GREEN: begin
        // Hold green with the timer parked at 0 while nothing else waits.
        if (expired && ((|pending) || night_mode)) begin
          state_n = S_AMBER;
          timer_n = TW'(T_AMBER - 1);
        end
      end
      S_AMBER: begin
        if (expired) begin
          state_n = S_ALL_RED;
          timer_n = TW'(T_CLEAR - 1);
        end
      end
      S_FLASH: begin
        if (!night_mode) begin
          state_n = S_ALL_RED;
          timer_n = TW'(T_CLEAR - 1);
        end else if (expired) begin
          timer_n = TW'(T_FLASH - 1);
          flash_n = ~flash_ph;
        end
      end
      default: begin
        state_n = S_ALL_RED;
        timer_n = TW'(T_CLEAR - 1);
      end
    endcase
  end

  // Request latching: the served approach is masked while it has right of way.
  always_comb begin
    mask      = ((state == S_RED_AMBER) || (state == S_GREEN)) ? dir_oh : '0;
    clr       = ra_done ? dir_oh : '0;
    pending_n = (pending & ~clr) | (demand & ~mask);
  end

  // Lamp word for the upcoming state so registered lamps change with state.
  always_comb begin
    lamp_n = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      if (state_n == S_FLASH) begin
        lamp_n[4*d +: 4] = flash_n ? L_DARK : L_AMBER;
      end else if (DIRW'(d) == dir_n) begin
        case (state_n)
          S_RED_AMBER: lamp_n[4*d +: 4] = L_RA;
          S_GREEN:     lamp_n[4*d +: 4] = L_GREEN;
          S_AMBER:     lamp_n[4*d +: 4] = L_AMBER;
          default:     lamp_n[4*d +: 4] = L_RED;
        endcase
      end else begin
        lamp_n[4*d +: 4] = L_RED;
      end
    end
  end

  // State, timer, grant, request and lamp registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_ALL_RED;
      timer      <= TW'(T_CLEAR - 1);
      active_dir <= DIRW'(NUM_DIR - 1);
      pending    <= '0;
      flash_ph   <= 1'b0;
      lamp       <= {NUM_DIR{L_RED}};
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_n;
      timer      <= timer_n;
      active_dir <= dir_n;
      pending    <= pending_n;
      flash_ph   <= flash_n;
      lamp       <= lamp_n;
    end
  end

endmodule

// File: tb/tb_traffic_rr.sv
// tb_traffic_rr: directed and random stimulus against a phase/age reference model.
module tb_traffic_rr;

  localparam int N       = 4;
  localparam int T_CLEAR = 3;
  localparam int T_RA    = 2;
  localparam int T_GREEN = 20;
  localparam int T_AMBER = 4;
  localparam int T_FLASH = 8;
  localparam int DIRW    = 2;

  localparam int P_AR = 0;
  localparam int P_RA = 1;
  localparam int P_GN = 2;
  localparam int P_AM = 3;
  localparam int P_FL = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   demand;
  logic           night_mode;
  logic [4*N-1:0] lamp;
  logic [DIRW-1:0] active_dir;
  logic [2:0]     state_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase, cycles spent in phase, granted approach, requests.
  int           m_ph;
  int           m_age;
  int           m_dir;
  logic [N-1:0] m_pend;

  always #5 clk = ~clk;

  traffic_rr #(
    .NUM_DIR(N), .T_CLEAR(T_CLEAR), .T_RA(T_RA),
    .T_GREEN(T_GREEN), .T_AMBER(T_AMBER), .T_FLASH(T_FLASH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .demand(demand),
    .night_mode(night_mode),
    .lamp(lamp),
    .active_dir(active_dir),
    .state_o(state_o)
  );

  function automatic int dur(input int ph);
    case (ph)
      P_AR:    return T_CLEAR;
      P_RA:    return T_RA;
      P_GN:    return T_GREEN;
      P_AM:    return T_AMBER;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_ph   = P_AR;
    m_age  = 0;
    m_dir  = N - 1;
    m_pend = '0;
  endtask

  task automatic model_step(input logic [N-1:0] dem, input logic ngt);
    bit           done;
    int           nph;
    int           ndir;
    logic [N-1:0] mask;
    logic [N-1:0] clr;
    done = (m_age >= dur(m_ph) - 1);
    nph  = m_ph;
    ndir = m_dir;
    mask = '0;
    clr  = '0;
    if (m_ph == P_RA || m_ph == P_GN) mask[m_dir] = 1'b1;
    case (m_ph)
      P_AR: if (done) begin
        if (ngt) nph = P_FL;
        else if (m_pend != '0) begin
          nph = P_RA;
          for (int k = 1; k <= N; k++) begin
            if (m_pend[(m_dir + k) % N]) begin
              ndir = (m_dir + k) % N;
              break;
            end
          end
        end
      end
      P_RA: if (done) begin
        nph = P_GN;
        clr[m_dir] = 1'b1;
      end
      P_GN: if (done && (m_pend != '0 || ngt)) nph = P_AM;
      P_AM: if (done) nph = P_AR;
      P_FL: if (!ngt) nph = P_AR;
      default: nph = P_AR;
    endcase
    m_pend = (m_pend & ~clr) | (dem & ~mask);
    m_age  = (nph != m_ph) ? 0 : m_age + 1;
    m_ph   = nph;
    m_dir  = ndir;
  endtask

  function automatic logic [4*N-1:0] exp_lamp();
    logic [4*N-1:0] e;
    for (int d = 0; d < N; d++) begin
      if (m_ph == P_FL) e[4*d +: 4] = (((m_age / T_FLASH) % 2) == 0) ? 4'b0001 : 4'b0000;
      else if (d != m_dir) e[4*d +: 4] = 4'b0010;
      else if (m_ph == P_RA) e[4*d +: 4] = 4'b0100;
      else if (m_ph == P_GN) e[4*d +: 4] = 4'b1000;
      else if (m_ph == P_AM) e[4*d +: 4] = 4'b0001;
      else e[4*d +: 4] = 4'b0010;
    end
    return e;
  endfunction

  task automatic check_all(input string tag);
    logic [DIRW-1:0] e_dir;
    logic [4*N-1:0]  e_lamp;
    int              lit;
    e_dir  = m_dir[DIRW-1:0];
    e_lamp = exp_lamp();
    checks++;
    assert (state_o === 3'(m_ph)) else begin
      failures++;
      $error("FAIL %s state got=%0d exp=%0d t=%0t", tag, state_o, m_ph, $time);
    end
    checks++;
    assert (active_dir === e_dir) else begin
      failures++;
      $error("FAIL %s active_dir got=%0d exp=%0d t=%0t", tag, active_dir, e_dir, $time);
    end
    checks++;
    assert (lamp === e_lamp) else begin
      failures++;
      $error("FAIL %s lamp got=%h exp=%h t=%0t", tag, lamp, e_lamp, $time);
    end
    if (state_o != 3'd4) begin
      lit = 0;
      for (int d = 0; d < N; d++)
        if (lamp[4*d +: 4] inside {4'b1000, 4'b0100, 4'b0001}) lit++;
      checks++;
      assert (lit <= 1) else begin
        failures++;
        $error("FAIL %s safety lit_approaches got=%0d exp<=1 t=%0t", tag, lit, $time);
      end
    end
  endtask

  task automatic step(input logic [N-1:0] dem, input logic ngt);
    demand     = dem;
    night_mode = ngt;
    @(posedge clk);
    model_step(dem, ngt);
    #1;
    check_all("step");
  endtask

  // Step with constant inputs until the model reaches phase ph (and dir, if >=0).
  task automatic run_until(input int ph, input int dir, input logic [N-1:0] dem,
                           input logic ngt, input int maxc, input string tag);
    int n;
    n = 0;
    while (!(m_ph == ph && (dir < 0 || m_dir == dir)) && n < maxc) begin
      step(dem, ngt);
      n++;
    end
    checks++;
    assert (m_ph == ph && (dir < 0 || m_dir == dir)) else begin
      failures++;
      $error("FAIL %s reach got_phase=%0d exp_phase=%0d after %0d cycles", tag, m_ph, ph, n);
    end
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [N-1:0] rd;
    reset      = 1'b0;
    demand     = '0;
    night_mode = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // Idle: stays in clearance with all red.
    repeat (50) step('0, 1'b0);

    // Single pulse on approach 2: served, then green held.
    repeat (4) step('0, 1'b0);
    step(4'b0100, 1'b0);
    run_until(P_GN, 2, '0, 1'b0, 20, "serve_dir2");
    repeat (30) step('0, 1'b0);

    // Approaches 0 and 3 together: round-robin from 2 serves 3 then 0.
    step(4'b1001, 1'b0);
    run_until(P_GN, 3, '0, 1'b0, 40, "serve_dir3");
    run_until(P_GN, 0, '0, 1'b0, 60, "serve_dir0");
    repeat (25) step('0, 1'b0);

    // Held demand on approach 1 while it is green, plus a pulse on 3.
    run_until(P_GN, 1, 4'b0010, 1'b0, 60, "serve_dir1");
    step(4'b1010, 1'b0);
    repeat (30) step(4'b0010, 1'b0);
    repeat (80) step('0, 1'b0);

    // Night mode raised 5 cycles into a green.
    step(4'b0100, 1'b0);
    run_until(P_GN, 2, '0, 1'b0, 40, "night_green");
    repeat (5) step('0, 1'b0);
    run_until(P_FL, -1, '0, 1'b1, 60, "enter_flash");
    step(4'b0001, 1'b1);
    for (int i = 0; i < 40; i++) begin
      rd = N'($urandom);
      step(($urandom_range(0, 3) == 0) ? rd : '0, 1'b1);
    end
    run_until(P_GN, -1, '0, 1'b0, 40, "after_flash");
    repeat (30) step('0, 1'b0);

    // Asynchronous reset while amber.
    step(4'b1111, 1'b0);
    run_until(P_AM, -1, '0, 1'b0, 80, "reach_amber");
    step('0, 1'b0);
    async_reset("reset_in_amber");
    repeat (10) step('0, 1'b0);

    // Random traffic with occasional night periods.
    for (int i = 0; i < 1500; i++) begin
      rd = N'($urandom);
      step(($urandom_range(0, 7) == 0) ? rd : '0, ((i / 250) % 3) == 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_rr.md
Name: traffic_rr

Overview:
- Parametrised N-way traffic-light controller; successor to the fixed two-approach, fixed-schedule controller.
- Serves NUM_DIR approaches one at a time in demand-driven round-robin order, with all-red clearance between them.
- Holds green when nothing else waits and supports a night flashing-amber mode.
- Sits between vehicle-sensor inputs and lamp drivers; one 4-bit one-hot lamp word per approach.

Parameters:
- NUM_DIR, 4, number of approaches (2..16).
- T_CLEAR, 3, all-red clearance cycles (>=1).
- T_RA, 2, red+amber cycles (>=1).
- T_GREEN, 20, minimum green cycles (>=1).
- T_AMBER, 4, amber cycles (>=1).
- T_FLASH, 8, half-period of night flashing in cycles (>=1).
- DIRW, $clog2(NUM_DIR), width of direction index (derived, localparam).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = asserted).
- demand  in  NUM_DIR  per-approach vehicle request, level, sampled every cycle.
- night_mode  in  1  request flashing-amber operation.
- lamp  out  4*NUM_DIR  lamp[4d+3:4d] for approach d; one-hot 1000 green, 0100 red+amber, 0010 red, 0001 amber, 0000 dark.
- active_dir  out  DIRW  approach currently or last granted.
- state_o  out  3  state code: 0 ALL_RED, 1 RED_AMBER, 2 GREEN, 3 AMBER, 4 FLASH.

Behaviour:
- Reset (async, while reset==0): state ALL_RED, timer = T_CLEAR-1, active_dir = NUM_DIR-1, pending = 0, every lamp = 0010, flash phase = 0.
- Timer: loaded with T_x-1 on state entry and decremented each cycle. "Expired" means timer==0, so each timed state lasts exactly T_x cycles.
- Pending register: pending_next = (pending & ~clr) | (demand & ~mask).
  - mask = one-hot(active_dir) while state is RED_AMBER or GREEN; 0 otherwise.
  - clr = one-hot(active_dir) on the RED_AMBER->GREEN transition cycle.
  - A demand arriving in that same cycle on another approach is kept.
- ALL_RED: all lamps 0010. On expiry:
  - night_mode=1 -> FLASH.
  - Else if pending!=0 -> RED_AMBER, with active_dir = first d with pending[d], searching active_dir+1, +2, ... modulo NUM_DIR, active_dir itself last.
  - Else stay in ALL_RED with timer held at 0, re-evaluating every cycle.
- RED_AMBER: lamp[active_dir] = 0100, others 0010. On expiry -> GREEN.
- GREEN: lamp[active_dir] = 1000, others 0010.
  - On expiry, if pending==0 and night_mode==0, hold GREEN with timer at 0.
  - Otherwise -> AMBER, leaving the next cycle.
- AMBER: lamp[active_dir] = 0001, others 0010. On expiry -> ALL_RED (timer T_CLEAR-1).
- FLASH: all lamps alternate 0001 / 0000, toggling every T_FLASH cycles and starting with 0001. Pending keeps accumulating.
  - When night_mode==0 is sampled -> ALL_RED with a full T_CLEAR, lamps 0010 from the next cycle.
- Night mode asserted mid-cycle never truncates a timed state. The current RED_AMBER/GREEN(min)/AMBER completes, then ALL_RED, then FLASH.
- Safety invariant: at most one approach shows any of 1000/0100/0001 outside FLASH. Every transition between approaches passes through ALL_RED for T_CLEAR cycles.
- Lamp outputs are registered; lamp changes appear in the cycle state changes.
- Reset asserted mid-operation: immediate return to reset values regardless of state. Pending requests are lost.

Test Plan:
- Reset then demand=0 for 50 cycles -> state_o stays 0, all lamps 0010, active_dir = NUM_DIR-1.
- NUM_DIR=4, one-cycle pulse on demand[2] at cycle 5 -> RED_AMBER on dir 2 after ALL_RED expiry. Green lasts 20 cycles, then holds; lamp[11:8]=1000, others 0010.
- Dir 2 holding green, pulse demand[0] and demand[3] together -> AMBER 4 cycles, ALL_RED 3, then dir 3 served (round-robin from 2). After dir 3's green and its transition, dir 0 is served.
- demand[1] held high continuously while dir 1 is green, plus a demand[3] pulse -> dir 1 is not re-queued; after dir 3 only re-served if demand[1] is still high after dir 1's green ended.
- night_mode raised 5 cycles into a green -> green completes 20 cycles, then AMBER 4, ALL_RED 3, then FLASH. Lamps toggle 0001/0000 every 8 cycles; dropping night_mode -> ALL_RED 3 cycles, then service of pending.
- reset pulled low during AMBER -> asynchronous return to ALL_RED, all 0010, pending cleared; releasing reset restarts the clearance count from T_CLEAR-1.
